// File: rtl/prog_mem_loader_if.sv
// prog_mem_loader_if: byte-stream input and RAM-port / status bundle of the
// program loader.
//
// Handshake: a byte moves on a rising clk edge where in_valid and in_ready
// are both 1. in_ready does not depend on in_valid. The source holds in_byte
// stable while in_valid=1 and in_ready=0. mem_w_en is a one-cycle strobe.
// mem_addr/mem_wdata are only meaningful when mem_w_en=1.
//
// state_dbg mirrors the loader state register:
// 0 = IDLE, 1 = COLLECT, 2 = WRITE, 3 = DONE.
interface prog_mem_loader_if;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_w_en;
    logic [11:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic [31:0] checksum;
    logic [1:0]  state_dbg;

    modport master (
        output start, in_valid, in_byte,
        input  in_ready, mem_w_en, mem_addr, mem_wdata,
        input  busy, cpu_hold, done, checksum, state_dbg
    );

    modport slave (
        input  start, in_valid, in_byte,
        output in_ready, mem_w_en, mem_addr, mem_wdata,
        output busy, cpu_hold, done, checksum, state_dbg
    );
endinterface

// File: rtl/prog_mem_loader.sv
// prog_mem_loader: assembles a little-endian byte stream into 32-bit words
// and writes them to RAM word addresses 0..WORD_COUNT-1. The loader keeps the
// CPU stalled while the load is in progress.
//
// Optional feature macro: LOADER_CHECKSUM_EN.
// When this macro is defined, checksum accumulates the written words modulo
// 2^32. When it is undefined, checksum is tied to 0.
module prog_mem_loader #(
    parameter int WORD_COUNT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    prog_mem_loader_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [11:0] LAST_ADDR = 12'(WORD_COUNT - 1);

    state_t      state;
    logic [1:0]  byte_cnt;
    logic [11:0] word_addr;
    logic [31:0] asm_word;
    logic [11:0] mem_addr_r;
    logic [31:0] mem_wdata_r;
    logic        in_ready_r;
    logic        mem_w_en_r;
    logic        busy_r;
    logic        done_r;
    logic [31:0] checksum_r;

    // A load may begin only from IDLE or DONE. A start while busy is ignored.
    logic start_ok;
    assign start_ok = bus.start && (state == IDLE || state == DONE);

    // Loader FSM. The strobe/status outputs are registered alongside the
    // state, so they never depend combinationally on the inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            byte_cnt    <= 2'd0;
            word_addr   <= 12'd0;
            asm_word    <= 32'd0;
            mem_addr_r  <= 12'd0;
            mem_wdata_r <= 32'd0;
            in_ready_r  <= 1'b0;
            mem_w_en_r  <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start_ok) begin
                        state      <= COLLECT;
                        byte_cnt   <= 2'd0;
                        word_addr  <= 12'd0;
                        asm_word   <= 32'd0;
                        in_ready_r <= 1'b1;
                        busy_r     <= 1'b1;
                        done_r     <= 1'b0;
                    end
                end
                COLLECT: begin
                    if (bus.in_valid) begin
                        asm_word[{byte_cnt, 3'b000} +: 8] <= bus.in_byte;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3) begin
                            // The fourth byte completes the word. Present the word
                            // on the RAM port for the single WRITE cycle.
                            state       <= WRITE;
                            mem_addr_r  <= word_addr;
                            mem_wdata_r <= {bus.in_byte, asm_word[23:0]};
                            in_ready_r  <= 1'b0;
                            mem_w_en_r  <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    mem_w_en_r <= 1'b0;
                    if (word_addr == LAST_ADDR) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end else begin
                        state      <= COLLECT;
                        word_addr  <= word_addr + 12'd1;
                        byte_cnt   <= 2'd0;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_CHECKSUM_EN
    // Running sum of every word written in this load. The sum restarts on an
    // accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum_r <= 32'd0;
        end else if (start_ok) begin
            checksum_r <= 32'd0;
        end else if (state == WRITE) begin
            checksum_r <= checksum_r + mem_wdata_r;
        end
    end
`else
    assign checksum_r = 32'd0;
`endif

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_w_en  = mem_w_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.busy      = busy_r;
    assign bus.cpu_hold  = busy_r;
    assign bus.done      = done_r;
    assign bus.checksum  = checksum_r;
    assign bus.state_dbg = state;

endmodule
